// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply-divide unit.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// are both high; op, rs1, rs2 and in_tag are sampled only on that edge.
// A response transfers on a rising edge where out_valid && out_ready are both
// high. result and out_tag stay stable while out_valid is high.
interface muldiv_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, op, rs1, rs2, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag
    );

    modport slave (
        input  in_valid, op, rs1, rs2, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fixup at the end.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    muldiv_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   b_q, b_d;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;      // product; low half doubles as dividend/quotient
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAGW-1:0]   tag_q, tag_d;

    logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, overflow;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Decode the incoming request: signedness, magnitudes and one-cycle special cases
    always_comb begin
        accept   = bus.in_valid && (state_q == S_IDLE) && !flush;
        is_div   = bus.op[2];
        a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg    = a_signed && bus.rs1[XLEN-1];
        b_neg    = b_signed && bus.rs2[XLEN-1];
        a_mag    = a_neg ? -bus.rs1 : bus.rs1;
        b_mag    = b_neg ? -bus.rs2 : bus.rs2;
        div_zero = is_div && (bus.rs2 == '0);
        overflow = is_div && !bus.op[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides everything else
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (div_zero || overflow) ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Outputs decoded from the state register or taken straight from flops
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.result    = result_q;
        bus.out_tag   = tag_q;
        dbg_state     = state_q;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   rem_wide, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Datapath: operand capture, one iteration per CALC cycle, sign fixup and select
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        tag_d    = tag_q;

        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_wide = {rem_q, acc_q[XLEN-1]};
        div_diff = rem_wide - {2'b00, b_q};
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    tag_d = bus.in_tag;
                    // remainder takes the dividend's sign, everything else the xor of signs
                    neg_d = (bus.op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                    rem_d = '0;
                    cnt_d = CW'(XLEN);
                    if (is_div) begin
                        b_d   = b_mag;
                        acc_d = {{XLEN{1'b0}}, a_mag};
                    end else begin
                        b_d   = a_mag;
                        acc_d = {{XLEN{1'b0}}, b_mag};
                    end
                    if (div_zero)      result_d = bus.op[1] ? bus.rs1 : '1;
                    else if (overflow) result_d = bus.op[1] ? '0 : bus.rs1;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q[2]) begin
                    if (!div_diff[XLEN+1]) begin
                        rem_d = div_diff[XLEN:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_wide[XLEN:0];
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
            end
            S_FIXUP: begin
                case (op_q)
                    3'b000:                 result_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                    3'b100, 3'b101:         result_d = quo_fix;
                    default:                result_d = rem_fix;
                endcase
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written corner sequences
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam int LAT_ITER = XLEN + 2;

  logic clk;
  logic rst;
  logic flush;
  logic [1:0] dbg_state;

  muldiv_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp_q[$];
  logic [TAGW-1:0] tag_q[$];
  int              lat_q[$];

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: plain integer arithmetic per RISC-V M rules
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    int          ia, ib;
    longint      la, lb;
    logic [63:0] p;
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin la = ia; lb = ib; p = la * lb; return p[63:32]; end
      3'd2: begin la = ia; lb = {32'b0, b}; p = la * lb; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h80000000 && b == '1) return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == '1) return '0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == '1) return 1;
    return LAT_ITER;
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h80000000;
      2: return '1;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: one request, wait for its result, hold it for 'stall' cycles, then release
  task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAGW-1:0] tag, input int stall,
                        output logic [XLEN-1:0] res, output logic [TAGW-1:0] rtag, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.in_tag = tag;
    bus.out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.rs1 = $urandom;
    bus.rs2 = $urandom;
    bus.in_tag = TAGW'($urandom);
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    repeat (stall) @(negedge clk);
    res = bus.result;
    rtag = bus.out_tag;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_release", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [XLEN-1:0] res, e;
    logic [TAGW-1:0] rtag, et;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    int              lat, el;
    bit              seen;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, LAT_ITER};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, LAT_ITER};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, LAT_ITER};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, LAT_ITER};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD, LAT_ITER};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFF, LAT_ITER};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd6,  32'd14,       LAT_ITER};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd7,  32'd2,        LAT_ITER};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        5'd10, 32'd5,        1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1};
    vecs[12] = '{3'd5, 32'hFFFFFFFF, 32'h00000001, 5'd13, 32'hFFFFFFFF, LAT_ITER};
    vecs[13] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, LAT_ITER};
    vecs[14] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd31, 32'd1,        LAT_ITER};

    apply_reset();

    // reset state
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_result", 64'(bus.result), 64'(0));
    check("reset_out_tag", 64'(bus.out_tag), 64'(0));

    // directed vectors
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, 0, res, rtag, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_tag", i), 64'(rtag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // backpressure: hold DONE for 10 cycles while offering divide-by-zero requests
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 3'd0;
    bus.rs1 = 32'd7;
    bus.rs2 = 32'hFFFFFFFD;
    bus.in_tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_latency", 64'(lat), 64'(LAT_ITER));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.op = 3'd4;
      bus.rs1 = $urandom;
      bus.rs2 = '0;
      bus.in_tag = 5'd22;
      @(posedge clk);
      @(negedge clk);
      check("bp_result", 64'(bus.result), 64'(32'hFFFFFFEB));
      check("bp_tag", 64'(bus.out_tag), 64'(9));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 64'(bus.in_ready), 64'(1));
    check("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("bp_no_hidden_accept", 64'(seen), 64'(0));

    // flush on the 10th CALC cycle
    bus.in_valid = 1'b1;
    bus.op = 3'd0;
    bus.rs1 = 32'd3;
    bus.rs2 = 32'd5;
    bus.in_tag = 5'd17;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc_in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_calc_out_valid", 64'(bus.out_valid), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) seen = 1'b1;
    end
    check("flush_calc_stays_idle", 64'(seen), 64'(0));

    // flush and request in the same IDLE cycle: request must be dropped
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.rs1 = 32'd5;
    bus.rs2 = '0;
    bus.in_tag = 5'd21;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_accept_in_ready", 64'(bus.in_ready), 64'(1));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_accept_no_result", 64'(seen), 64'(0));

    // asynchronous reset while a result is buffered
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.rs1 = 32'd5;
    bus.rs2 = '0;
    bus.in_tag = 5'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rst_pre_out_valid", 64'(bus.out_valid), 64'(1));
    check("rst_pre_result", 64'(bus.result), 64'(32'hFFFFFFFF));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_async_result", 64'(bus.result), 64'(0));
    check("rst_async_out_tag", 64'(bus.out_tag), 64'(0));
    check("rst_async_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;

    // random operations against the reference model
    for (int n = 0; n < 45; n++) begin
      op = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      et = TAGW'($urandom);
      exp_q.push_back(ref_result(op, a, b));
      tag_q.push_back(et);
      lat_q.push_back(ref_latency(op, a, b));
      run_op(op, a, b, et, $urandom_range(0, 3), res, rtag, lat);
      e = exp_q.pop_front();
      et = tag_q.pop_front();
      el = lat_q.pop_front();
      check($sformatf("rand%0d_op%0d_%h_%h_result", n, op, a, b), 64'(res), 64'(e));
      check($sformatf("rand%0d_tag", n), 64'(rtag), 64'(et));
      check($sformatf("rand%0d_latency", n), 64'(lat), 64'(el));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised RV32M/RV64M multiply-divide unit that sits beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time through a valid/ready handshake and computes it over XLEN iterations. Divide-by-zero and signed-overflow cases complete in one cycle. The result is held in an output buffer with a tag until the writeback stage accepts it, and a flush input aborts any operation in flight.

## Interface
- XLEN, 32: operand and result width; must be ≥ 8 and a power of 2.
- TAGW, 5: width of the passthrough tag (destination register index).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; highest priority after rst.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; equals (state == IDLE).
- op  input  3  RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  first operand (multiplicand / dividend).
- rs2  input  XLEN  second operand (multiplier / divisor).
- in_tag  input  TAGW  tag captured with the operands.
- out_valid  output  1  result available; equals (state == DONE).
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  registered result.
- out_tag  output  TAGW  registered tag of the result.

## Operation
- States:
  - IDLE: accepting requests.
  - CALC: iterating; a counter holds the remaining iterations.
  - FIXUP: sign correction and result selection.
  - DONE: result buffered.
- IDLE transitions, on in_valid && in_ready:
  - Latch op, in_tag, and the operand magnitudes.
  - Latch the sign flags: signed-operand flag per op (MULH: both operands; MULHSU: rs1 only; DIV/REM: both), negate-result flag, and the special-case class.
  - Divide by zero (DIV/DIVU/REM/REMU with rs2 == 0): go to DONE. Result is all-ones for DIV/DIVU and rs1 for REM/REMU.
  - Signed overflow (DIV/REM, rs1 == 1 followed by XLEN-1 zeros, i.e. the most negative value, and rs2 == all-ones): go to DONE. Result is rs1 for DIV and 0 for REM.
  - All other cases: counter = XLEN, go to CALC.
- Multiply in CALC: shift-add on unsigned magnitudes into a 2·XLEN accumulator, one multiplier bit per cycle.
- Divide in CALC: restoring division on unsigned magnitudes, one quotient bit per cycle. The remainder register is XLEN+1 bits wide.
- CALC exits to FIXUP when the counter reaches 0.
- FIXUP behaviour:
  - Negate (two's complement) as follows: the product if the operand signs differ; the quotient if the dividend and divisor signs differ; the remainder if the dividend is negative.
  - Select product[XLEN-1:0] for MUL, product[2·XLEN-1:XLEN] for the MULH variants, the quotient for DIV/DIVU, and the remainder for REM/REMU.
  - Go to DONE.
- DONE holds result and out_tag stable until out_valid && out_ready, then returns to IDLE. There is no same-cycle new acceptance; in_ready rises in the following cycle.
- in_valid is ignored in every state other than IDLE. Operands need not be held after acceptance.
- flush in any state goes to IDLE on the next edge. A buffered or partial result is discarded and out_valid drops. flush has priority over acceptance in the same cycle.
- Arithmetic is modulo 2^XLEN, with no exceptions raised.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1, result 0, out_tag 0, counter 0, internal accumulators 0.
- Reset asserted mid-operation forces these values immediately, without waiting for a clock edge.
- Normal operation: accepted at edge E. out_valid is high in the cycle after edge E+XLEN+1, giving XLEN+2 cycles of latency (34 for XLEN=32).
- Special case (divide by zero, overflow): out_valid is high in the cycle after edge E, giving 1 cycle of latency.
- Minimum initiation interval is latency + 1 cycles, with out_ready held high.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.

## Test plan
- MUL with XLEN=32, rs1=7, rs2=0xFFFFFFFD, tag=9 -> result 0xFFFFFFEB, out_tag 9, out_valid first high 34 cycles after acceptance.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero and overflow, each with out_valid high one cycle after acceptance:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000/0xFFFFFFFF -> 0.
- Backpressure: hold out_ready low 10 cycles in DONE while toggling in_valid -> result and out_tag stable, in_ready 0, no new acceptance. Raising out_ready -> IDLE next edge, in_ready 1.
- Abort and reset:
  - flush on the 10th CALC cycle -> IDLE next edge, out_valid never asserts.
  - flush and in_valid in the same IDLE cycle -> request not accepted.
  - rst pulsed between edges during DONE -> out_valid 0 and result 0 immediately.
